// File: rtl/rptr_handler.sv
// Read-side pointer handler for an asynchronous FIFO (read clock domain).
// Keeps the binary and Gray read pointers and the memory read address.
// Produces registered empty, almost-empty, occupancy and a sticky underflow
// flag from the write pointer, which arrives already synchronised as Gray code.
module rptr_handler #(
  parameter int PTR_SIZE = 8,
  parameter int AE_LEVEL = 2
) (
  input  logic                r_clk,
  input  logic                rrst,
  input  logic                r_en,
  input  logic [PTR_SIZE:0]   g_wptr_sync,
  input  logic                underflow_clr,
  output logic [PTR_SIZE:0]   b_rptr,
  output logic [PTR_SIZE:0]   g_rptr,
  output logic [PTR_SIZE-1:0] r_addr,
  output logic                empty,
  output logic                almost_empty,
  output logic [PTR_SIZE:0]   r_count,
  output logic                underflow
);

  localparam logic [PTR_SIZE:0] AE_THRESH = (PTR_SIZE+1)'(AE_LEVEL);

  logic [PTR_SIZE:0] b_rptr_q, b_rptr_d;
  logic [PTR_SIZE:0] g_rptr_q, g_rptr_d;
  logic [PTR_SIZE:0] r_count_q, r_count_d;
  logic              empty_q, empty_d;
  logic              almost_empty_q, almost_empty_d;
  logic              underflow_q, underflow_d;
  logic              rd_ok;
  logic [PTR_SIZE:0] b_wptr_sync;

  // Gray-to-binary conversion of the synchronised write pointer: each binary
  // bit is the XOR of all Gray bits from the MSB down to that position.
  assign b_wptr_sync[PTR_SIZE] = g_wptr_sync[PTR_SIZE];
  generate
    for (genvar gi = PTR_SIZE - 1; gi >= 0; gi--) begin : g_gray2bin
      assign b_wptr_sync[gi] = b_wptr_sync[gi+1] ^ g_wptr_sync[gi];
    end
  endgenerate

  // Next-state logic; all flags derive from the next pointer so they carry no extra lag.
  always_comb begin
    rd_ok          = r_en & ~empty_q;
    b_rptr_d       = b_rptr_q + {{PTR_SIZE{1'b0}}, rd_ok};
    g_rptr_d       = (b_rptr_d >> 1) ^ b_rptr_d;
    empty_d        = (g_rptr_d == g_wptr_sync);
    r_count_d      = b_wptr_sync - b_rptr_d;
    almost_empty_d = (r_count_d <= AE_THRESH);
    // Setting has priority over clearing in the same cycle.
    underflow_d    = (r_en & empty_q) | (underflow_q & ~underflow_clr);
  end

  // State registers with synchronous reset to the empty FIFO state.
  always_ff @(posedge r_clk) begin
    if (rrst) begin
      b_rptr_q       <= '0;
      g_rptr_q       <= '0;
      r_count_q      <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      b_rptr_q       <= b_rptr_d;
      g_rptr_q       <= g_rptr_d;
      r_count_q      <= r_count_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
    end
  end

  assign b_rptr       = b_rptr_q;
  assign g_rptr       = g_rptr_q;
  assign r_addr       = b_rptr_q[PTR_SIZE-1:0];
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign r_count      = r_count_q;
  assign underflow    = underflow_q;

endmodule

// File: doc/rptr_handler.md
Name: rptr_handler

Overview:
Read-side pointer handler of the async FIFO, running in the read clock domain. It consumes the write pointer after it has been synchronised into the read domain as Gray code. It produces the binary read address for the memory and the Gray read pointer sent back to the write domain. It also generates the registered empty flag, an almost-empty flag, an occupancy count and a sticky underflow error.

Parameters:
PTR_SIZE, 8, address width; FIFO depth = 2**PTR_SIZE; pointers are PTR_SIZE+1 bits (extra wrap bit).
AE_LEVEL, 2, almost_empty asserts when occupancy <= AE_LEVEL; legal range 0..2**PTR_SIZE-1.

Ports:
r_clk  input  1  read-domain clock; all state updates on rising edge.
rrst  input  1  synchronous active-high reset.
r_en  input  1  read request from consumer.
g_wptr_sync  input  PTR_SIZE+1  write pointer, Gray code, already 2-flop synchronised into r_clk.
underflow_clr  input  1  clears sticky underflow.
b_rptr  output  PTR_SIZE+1  binary read pointer (registered).
g_rptr  output  PTR_SIZE+1  Gray read pointer (registered) for the write-domain synchroniser.
r_addr  output  PTR_SIZE  memory read address = b_rptr[PTR_SIZE-1:0].
empty  output  1  registered empty flag.
almost_empty  output  1  registered, occupancy <= AE_LEVEL.
r_count  output  PTR_SIZE+1  registered occupancy as seen from the read domain, 0..2**PTR_SIZE.
underflow  output  1  sticky, set on a read attempt while empty.

Behaviour:
- Reset (rrst=1 at an r_clk edge, regardless of other inputs, including mid-operation):
  - b_rptr=0, g_rptr=0, empty=1, almost_empty=1, r_count=0, underflow=0.
- Read accept: rd_ok = r_en & ~empty, using the registered empty flag.
  - b_rptr_next = b_rptr + rd_ok, modulo 2**(PTR_SIZE+1).
  - g_rptr_next = (b_rptr_next>>1) ^ b_rptr_next.
  - Both pointers are registered every cycle.
- Wrap-around:
  - b_rptr rolls from 2**(PTR_SIZE+1)-1 to 0.
  - The Gray MSB toggles every 2**PTR_SIZE reads.
  - r_addr wraps every 2**PTR_SIZE reads.
- Empty: empty <= (g_rptr_next == g_wptr_sync), a full-width compare including the wrap bit.
  - Empty deasserts one r_clk after g_wptr_sync changes.
  - Empty asserts in the same edge that consumes the last word; there is no extra read accepted.
- Occupancy:
  - b_wptr_sync = Gray-to-binary of g_wptr_sync (combinational XOR prefix from MSB).
  - r_count <= b_wptr_sync - b_rptr_next, modulo PTR_SIZE+1 bits.
  - Maximum legal value is 2**PTR_SIZE (full); values above that are never produced with a legal write side.
- almost_empty <= (count_next <= AE_LEVEL), same cycle timing as r_count.
- Underflow:
  - Set when r_en=1 and empty=1 at an edge; pointers do not move.
  - Cleared by underflow_clr=1.
  - Set wins over clear in the same cycle.
  - Reset clears it.
- Simultaneous read and write-pointer advance in one cycle: count_next reflects both (net unchanged for +1/-1).
- Latency: pointer update 1 cycle after accept; flags are registered from next-state values, so there is no extra lag.
- No combinational path from any input to any output except r_addr, which is a direct slice of the registered b_rptr.

Test Plan:
All scenarios use PTR_SIZE=3, AE_LEVEL=2.
1. Reset: rrst=1 for 2 cycles, r_en=1, g_wptr_sync=0 -> b_rptr=0, g_rptr=0, empty=1, almost_empty=1, r_count=0, underflow=0.
2. Fill seen: g_wptr_sync=4'b0110 (bin 4), r_en=0 -> after 1 edge empty=0, r_count=4, almost_empty=0.
3. Drain: from scenario 2, r_en=1 for 5 cycles.
   - b_rptr 1,2,3,4 then holds 4.
   - g_rptr 0001,0011,0010,0110.
   - r_count 3,2,1,0.
   - almost_empty=1 from count 2.
   - empty=1 on the 4th edge.
   - 5th cycle: underflow=1, pointers unchanged.
4. Wrap: b_rptr=15 (g_rptr=1000), g_wptr_sync=4'b0000 (bin 0), so r_count=1. One read -> b_rptr=0, g_rptr=0000, r_addr=0, empty=1, r_count=0.
5. Full occupancy and concurrent update:
   - b_rptr=0, g_wptr_sync=4'b1100 (bin 8) -> r_count=8, empty=0.
   - Then r_en=1 while g_wptr_sync steps to 1101 (bin 9) -> r_count stays 8, b_rptr=1.
6. Sticky/reset:
   - underflow=1, then underflow_clr=1 with r_en=1 and empty=1 in the same cycle -> underflow stays 1.
   - underflow_clr alone -> 0.
   - rrst pulse mid-drain (b_rptr=3) -> all outputs at reset values after that edge.
